// File: rtl/riscv_defines.sv
// Shared RISC-V definitions: word width, M-extension funct3 encoding and MDU sequencer states.
package riscv_defines;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_DONE
  } mdu_state_e;

  function automatic logic op_signed_a(mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op_signed_b(mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: one shared 2*W accumulator runs radix-2
// shift-add or restoring shift-subtract on operand magnitudes, then fixes the sign.
module mdu_sequencer #(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            funct_i,
  input  logic [WORD_WIDTH-1:0] rs1_i,
  input  logic [WORD_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] result_o
);
  import riscv_defines::*;

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   result_q, result_d;
  mdu_op_e        funct_q, funct_d;
  logic           neg_q, neg_d;

  mdu_op_e        op_in;
  logic           sa, sb, div_zero, div_ovf;
  logic [W-1:0]   mag_a, mag_b, quo_rem, fin;
  logic [W:0]     mul_sum, div_hi, div_diff;
  logic [2*W-1:0] acc_nx, prod;

  assign op_in    = mdu_op_e'(funct_i);
  assign sa       = op_signed_a(op_in) & rs1_i[W-1];
  assign sb       = op_signed_b(op_in) & rs2_i[W-1];
  assign mag_a    = sa ? -rs1_i : rs1_i;
  assign mag_b    = sb ? -rs2_i : rs2_i;
  assign div_zero = funct_i[2] & (rs2_i == '0);
  assign div_ovf  = (op_in == MDU_DIV || op_in == MDU_REM) && rs1_i == MIN_NEG && rs2_i == '1;

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  // Divide:   acc = {partial remainder, dividend/quotient}, shifted left each step.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_hi   = acc_q[2*W-1:W-1];
  assign div_diff = div_hi - {1'b0, opb_q};
  assign acc_nx   = funct_q[2]
                  ? (div_diff[W] ? {div_hi[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc_q[W-2:0], 1'b1})
                  : {mul_sum, acc_q[W-1:1]};
  assign prod     = neg_q ? -acc_nx : acc_nx;
  assign quo_rem  = funct_q[1] ? acc_nx[2*W-1:W] : acc_nx[W-1:0];
  assign fin      = funct_q[2] ? (neg_q ? -quo_rem : quo_rem)
                  : (funct_q == MDU_MUL ? prod[W-1:0] : prod[2*W-1:W]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    stall_o  = 1'b0;
    valid_o  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          funct_d = op_in;
          neg_d   = (op_in == MDU_REM) ? sa : (sa ^ sb);
          cnt_d   = '0;
          if (div_zero) begin
            result_d = funct_i[1] ? rs1_i : '1;
            state_d  = MDU_DONE;
          end else if (div_ovf) begin
            result_d = funct_i[1] ? '0 : MIN_NEG;
            state_d  = MDU_DONE;
          end else begin
            acc_d   = {{W{1'b0}}, funct_i[2] ? mag_a : mag_b};
            opb_d   = funct_i[2] ? mag_b : mag_a;
            state_d = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        stall_o = 1'b1;
        acc_d   = acc_nx;
        if (cnt_q == CW'(W-1)) begin
          cnt_d    = '0;
          result_d = fin;
          state_d  = MDU_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MDU_DONE: begin
        valid_o = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    // A killed operation must leave neither a pulse nor a visible result behind.
    if (flush_i) begin
      state_d  = MDU_IDLE;
      valid_o  = 1'b0;
      result_d = result_q;
    end
    if (rst_i) stall_o = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      funct_q  <= MDU_MUL;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, sets the operand and result width in bits.
REQ-002 clk_i  in  1  core clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  request; driven by mdu_op_ctrl_o of control_unit gated by the valid execute stage.
REQ-005 funct_i  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_i, rs2_i  in  WORD_WIDTH  operands (rs1 dividend/multiplicand, rs2 divisor/multiplier).
REQ-007 flush_i  in  1  kill any operation in flight.
REQ-008 stall_o  out  1  holds the pipeline while an operation is accepted or running.
REQ-009 valid_o  out  1  one-cycle pulse; result_o is valid.
REQ-010 result_o  out  WORD_WIDTH  operation result.

Function
REQ-011 FSM states: IDLE, CALC, DONE.
REQ-012 IDLE with start_i=1 and flush_i=0: accept in this cycle (cycle 0), latch operand magnitudes, result sign, and funct_i, then go to CALC.
REQ-013 Signedness: MUL/MULH/DIV/REM signed on both operands; MULHSU signed rs1 and unsigned rs2; MULHU/DIVU/REMU unsigned.
REQ-014 CALC runs exactly WORD_WIDTH iterations, one per cycle, using an iteration counter that counts 0..WORD_WIDTH-1 and does not wrap.
REQ-015 Multiply: radix-2 shift-add of magnitudes into a 2*WORD_WIDTH product; negate at the end when the result sign is negative.
REQ-016 Divide: restoring shift-subtract on magnitudes. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-017 Leaving CALC after the last iteration goes to DONE. DONE drives valid_o=1 for one cycle and then returns to IDLE.
REQ-018 Result select: MUL takes the low word; MULH, MULHSU and MULHU take the high word; DIV/DIVU take the quotient; REM/REMU take the remainder.
REQ-019 Normal latency: acceptance in cycle 0, valid_o in cycle WORD_WIDTH+1.
REQ-020 Divide by zero (rs2=0), detected at acceptance, skips CALC and goes straight to DONE (valid_o in cycle 1):
  - DIV/DIVU return all ones.
  - REM/REMU return rs1.
REQ-021 Signed overflow (DIV/REM with rs1=most-negative and rs2=all ones) skips CALC:
  - DIV returns the most-negative value.
  - REM returns 0.
REQ-022 stall_o = (IDLE and start_i and not flush_i) or CALC. stall_o is 0 in DONE, so the pipeline advances on the valid_o cycle.
REQ-023 start_i is ignored in CALC and DONE; no request is queued.
REQ-024 flush_i in any state: next state is IDLE; valid_o is not asserted for the killed operation.
REQ-025 flush_i and start_i together in IDLE: flush wins, nothing is accepted.
REQ-026 result_o holds its last value outside DONE.

Reset
REQ-027 While rst_i=1:
  - state is IDLE and the counter is 0.
  - valid_o=0, stall_o=0.
  - result_o=0 and all datapath registers are 0.
REQ-028 Reset in the middle of an operation abandons it immediately. No valid_o follows after rst_i is released.

Structure
REQ-029 WORD_WIDTH, the funct3 mdu_op enum and the FSM state enum belong in the shared riscv_defines package.
REQ-030 Single module with no sub-module: the FSM and the 2*WORD_WIDTH iteration register share one datapath for both multiply and divide.

Verification
REQ-031 MUL with rs1=7, rs2=-3: stall_o is high for 33 cycles, then valid_o in cycle 33 with result_o=0xFFFFFFEB.
REQ-032 MULHU with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF: result_o=0xFFFFFFFE. MULHSU with rs1=-1, rs2=0xFFFFFFFF: result_o=0xFFFFFFFF.
REQ-033 DIV with rs1=-7, rs2=2: result_o=-3. REM with the same operands: result_o=-1. DIVU with rs1=100, rs2=7: result_o=14.
REQ-034 DIVU and REMU with rs1=5, rs2=0: valid_o in cycle 1 with results 0xFFFFFFFF and 5. DIV with rs1=0x80000000, rs2=-1: result_o=0x80000000, and REM with the same operands gives 0.
REQ-035 Start DIV, assert flush_i at cycle 10, then start MUL 3*4 together with a second flush_i: no valid_o for either. A later MUL 3*4 gives 12 after 33 cycles.
REQ-036 Assert rst_i at cycle 5 of a DIV: all outputs go to 0 immediately, and valid_o never pulses.
